// File: rtl/sccb_write_master_pkg.sv
// sccb_write_master_pkg: shared types and constants for the SCCB write engine.
// Holds the FSM state enum, the frame geometry and the camera device address.
package sccb_write_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    BIT,
    STOP,
    DONE
  } state_t;

  localparam int START_Q        = 2;
  localparam int STOP_Q         = 3;
  localparam int SLOTS_PER_BYTE = 9;
  localparam int BYTES          = 4;

  localparam logic [7:0] DEV_ADDR = 8'h78;

endpackage

// File: rtl/sccb_qtick_gen.sv
// sccb_qtick_gen: quarter bit-period divider, one-cycle qtick every QDIV clocks.
// Ports: clk_25M, rst_100 (async high), clr (sync hold at 0), qtick (out).
module sccb_qtick_gen #(
  parameter int QDIV = 312
) (
  input  logic clk_25M,
  input  logic rst_100,
  input  logic clr,
  output logic qtick
);

  logic [15:0] cnt;

  assign qtick = !clr && (cnt == 16'(QDIV - 1));

  always_ff @(posedge clk_25M or posedge rst_100) begin
    if (rst_100) begin
      cnt <= '0;
    end else if (clr || qtick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/sccb_write_master.sv
// sccb_write_master: serialises one 32-bit word as an SCCB write frame.
// Ports: clk_25M, rst_100, cfg_data, i2c_req/i2c_ack, sclk, sda_out/oe/in, ack_err, busy.
module sccb_write_master
  import sccb_write_master_pkg::*;
#(
  parameter int QDIV = 312
) (
  input  logic        clk_25M,
  input  logic        rst_100,
  input  logic [31:0] cfg_data,
  input  logic        i2c_req,
  output logic        i2c_ack,
  output logic        sclk,
  output logic        sda_out,
  output logic        sda_oe,
  input  logic        sda_in,
  output logic        ack_err,
  output logic        busy
);

  state_t      state, state_d;
  logic [1:0]  q, q_d;
  logic [2:0]  bit_cnt, bit_d;
  logic        ack_slot, ack_slot_d;
  logic [1:0]  byte_cnt, byte_d;
  logic [31:0] shreg, sh_d;
  logic        err_d, iack_d, busy_d;
  logic        qtick;
  logic        qclr;

  // divider idles outside a frame so each frame starts phase-aligned
  assign qclr = (state == IDLE) || (state == DONE);

  sccb_qtick_gen #(
    .QDIV (QDIV)
  ) u_qtick (
    .clk_25M (clk_25M),
    .rst_100 (rst_100),
    .clr     (qclr),
    .qtick   (qtick)
  );

  always_ff @(posedge clk_25M or posedge rst_100) begin
    if (rst_100) begin
      state    <= IDLE;
      q        <= '0;
      bit_cnt  <= '0;
      ack_slot <= 1'b0;
      byte_cnt <= '0;
      shreg    <= '0;
      ack_err  <= 1'b0;
      i2c_ack  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      q        <= q_d;
      bit_cnt  <= bit_d;
      ack_slot <= ack_slot_d;
      byte_cnt <= byte_d;
      shreg    <= sh_d;
      ack_err  <= err_d;
      i2c_ack  <= iack_d;
      busy     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state;
    q_d        = q;
    bit_d      = bit_cnt;
    ack_slot_d = ack_slot;
    byte_d     = byte_cnt;
    sh_d       = shreg;
    err_d      = ack_err;
    iack_d     = i2c_ack;
    busy_d     = busy;
    sclk       = 1'b1;
    sda_out    = 1'b1;
    sda_oe     = 1'b1;
    unique case (state)
      IDLE: begin
        if (i2c_req && !i2c_ack) begin
          sh_d       = cfg_data;
          err_d      = 1'b0;
          busy_d     = 1'b1;
          q_d        = '0;
          bit_d      = 3'd7;
          ack_slot_d = 1'b0;
          byte_d     = '0;
          state_d    = START;
        end
      end
      START: begin
        sda_out = (q == 2'd0);
        if (qtick) begin
          if (q == 2'(START_Q - 1)) begin
            q_d     = '0;
            state_d = BIT;
          end else begin
            q_d = q + 2'd1;
          end
        end
      end
      BIT: begin
        sclk    = (q == 2'd1) || (q == 2'd2);
        sda_out = ack_slot ? 1'b1 : shreg[31];
        sda_oe  = !ack_slot;
        if (qtick) begin
          q_d = q + 2'd1;
          if (q == 2'd2 && ack_slot && sda_in) begin
            err_d = 1'b1;
          end
          if (q == 2'd3) begin
            if (ack_slot) begin
              ack_slot_d = 1'b0;
              bit_d      = 3'd7;
              if (byte_cnt == 2'(BYTES - 1)) begin
                state_d = STOP;
              end else begin
                byte_d = byte_cnt + 2'd1;
              end
            end else begin
              sh_d = {shreg[30:0], 1'b0};
              if (bit_cnt == 3'd0) begin
                ack_slot_d = 1'b1;
              end else begin
                bit_d = bit_cnt - 3'd1;
              end
            end
          end
        end
      end
      STOP: begin
        sclk    = (q != 2'd0);
        sda_out = (q == 2'd2);
        if (qtick) begin
          if (q == 2'(STOP_Q - 1)) begin
            q_d     = '0;
            busy_d  = 1'b0;
            iack_d  = 1'b1;
            state_d = DONE;
          end else begin
            q_d = q + 2'd1;
          end
        end
      end
      DONE: begin
        if (!i2c_req) begin
          iack_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sccb_write_master.sv
// tb_sccb_write_master: randomized scoreboard bench with a bus-level slave.
// Checks frames, ack timing, NACK flagging, reset abort and SCL timing.
module tb_sccb_write_master;
  import sccb_write_master_pkg::*;

  localparam int QDIV = 2;

  logic        clk_25M = 1'b0;
  logic        rst_100 = 1'b1;
  logic [31:0] cfg_data = '0;
  logic        i2c_req = 1'b0;
  logic        sda_in = 1'b1;
  logic        i2c_ack, sclk, sda_out, sda_oe, ack_err, busy;

  sccb_write_master #(
    .QDIV (QDIV)
  ) dut (
    .clk_25M  (clk_25M),
    .rst_100  (rst_100),
    .cfg_data (cfg_data),
    .i2c_req  (i2c_req),
    .i2c_ack  (i2c_ack),
    .sclk     (sclk),
    .sda_out  (sda_out),
    .sda_oe   (sda_oe),
    .sda_in   (sda_in),
    .ack_err  (ack_err),
    .busy     (busy)
  );

  always #5 clk_25M = ~clk_25M;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always @(posedge clk_25M) cyc <= cyc + 1;

  task automatic chk32(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] word;
    logic [3:0]  nack;
  } exp_t;

  exp_t exp_q[$];

  logic [3:0]  nack_mask = '0;
  int          nstart = 0;
  int          nstop = 0;
  int          nbits = 0;
  int          nfall = 0;
  int          run = 0;
  bit          collecting = 0;
  logic        prev_scl = 1'b1;
  logic        prev_sda = 1'b1;
  logic        bus;
  logic [31:0] data;
  logic [3:0]  acks;

  // bus monitor, slave responder and scoreboard checker
  always begin
    @(posedge clk_25M);
    #1;
    bus = sda_oe ? sda_out : sda_in;
    if (rst_100) begin
      collecting = 0;
      sda_in     = 1'b1;
      prev_scl   = 1'b1;
      prev_sda   = 1'b1;
      run        = 0;
    end else begin
      if (prev_scl && sclk && prev_sda && !bus) begin
        chk1("nested_start", collecting, 1'b0);
        nstart++;
        collecting = 1;
        nbits = 0;
        nfall = 0;
        data = '0;
        acks = '0;
      end else if (prev_scl && sclk && !prev_sda && bus) begin
        nstop++;
        chk32("stop_bits", nbits, 36);
        chk1("sb_nonempty", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          chk32("frame_data", data, e.word);
          chk32("frame_acks", {28'd0, acks}, {28'd0, e.nack});
        end
        collecting = 0;
      end else if (collecting && !prev_scl && sclk) begin
        if (nbits > 0) chk32("scl_low", run, 2 * QDIV);
        if (nbits < BYTES * SLOTS_PER_BYTE) begin
          if (nbits % SLOTS_PER_BYTE == 8)
            acks[nbits / SLOTS_PER_BYTE] = bus;
          else
            data = {data[30:0], bus};
          nbits++;
        end
      end else if (collecting && prev_scl && !sclk) begin
        if (nfall > 0) chk32("scl_high", run, 2 * QDIV);
        nfall++;
        if (nbits % SLOTS_PER_BYTE == 8) begin
          sda_in = nack_mask[nbits / SLOTS_PER_BYTE];
        end else if (nbits % SLOTS_PER_BYTE == 0 && nbits > 0) begin
          logic e_err;
          sda_in = 1'b1;
          e_err = 1'b0;
          for (int i = 0; i < nbits / SLOTS_PER_BYTE; i++)
            e_err |= nack_mask[i];
          chk1("ack_err_live", ack_err, e_err);
        end
      end
      if (sclk != prev_scl) run = 1;
      else run++;
      prev_scl = sclk;
      prev_sda = bus;
    end
  end

  int exp_starts = 0;

  task automatic xfer(input logic [31:0] w, input logic [3:0] m,
                      input bit early, input int hold,
                      input logic [31:0] next_w);
    int n, s0, t0;
    @(negedge clk_25M);
    cfg_data  = w;
    nack_mask = m;
    i2c_req   = 1'b1;
    t0 = cyc + 1;
    exp_q.push_back('{w, m});
    exp_starts++;
    @(negedge clk_25M);
    chk1("busy_latch", busy, 1'b1);
    chk1("ack_err_clear", ack_err, 1'b0);
    repeat (3) @(negedge clk_25M);
    cfg_data = $urandom;
    if (early) i2c_req = 1'b0;
    n = 0;
    while (!i2c_ack && n < 149 * QDIV + 10) begin
      @(negedge clk_25M);
      n++;
    end
    chk32("ack_latency", 32'(cyc - t0), 32'(149 * QDIV));
    chk1("ack_err_final", ack_err, |m);
    chk1("busy_done", busy, 1'b0);
    if (hold > 0) begin
      s0 = nstart;
      cfg_data = next_w;
      repeat (hold) @(negedge clk_25M);
      chk1("hold_ack", i2c_ack, 1'b1);
      chk1("hold_busy", busy, 1'b0);
      chk32("hold_no_start", nstart, s0);
      chk1("hold_ack_err", ack_err, |m);
    end
    i2c_req = 1'b0;
    @(negedge clk_25M);
    chk1("ack_fall", i2c_ack, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, s0, p0;
    repeat (2) @(negedge clk_25M);
    chk1("rst_sclk", sclk, 1'b1);
    chk1("rst_sda_out", sda_out, 1'b1);
    chk1("rst_sda_oe", sda_oe, 1'b1);
    chk1("rst_i2c_ack", i2c_ack, 1'b0);
    chk1("rst_ack_err", ack_err, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    rst_100 = 1'b0;
    repeat (3) @(negedge clk_25M);

    xfer(32'h7831_0311, 4'b0000, 0, 0, '0);
    xfer(32'h7831_0311, 4'b0010, 0, 0, '0);

    s0 = nstart;
    p0 = nstop;
    xfer(32'h7830_0882, 4'b0000, 0, 20, 32'h7830_0842);
    xfer(32'h7830_0842, 4'b0000, 0, 0, '0);
    chk32("b2b_starts", nstart - s0, 2);
    chk32("b2b_stops", nstop - p0, 2);

    @(negedge clk_25M);
    cfg_data  = 32'h7831_0311;
    nack_mask = '0;
    i2c_req   = 1'b1;
    t0 = cyc + 1;
    exp_q.push_back('{32'h7831_0311, 4'b0000});
    exp_starts++;
    while (cyc < t0 + 82 * QDIV + 1) @(negedge clk_25M);
    chk32("abort_point", nbits, 20);
    rst_100 = 1'b1;
    #1;
    chk1("abort_sclk", sclk, 1'b1);
    chk1("abort_sda_oe", sda_oe, 1'b1);
    chk1("abort_sda_out", sda_out, 1'b1);
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_i2c_ack", i2c_ack, 1'b0);
    exp_q.delete(exp_q.size() - 1);
    i2c_req = 1'b0;
    @(negedge clk_25M);
    rst_100 = 1'b0;
    repeat (2) @(negedge clk_25M);
    xfer(32'h7831_0311, 4'b0000, 0, 0, '0);

    for (int i = 0; i < 6; i++) begin
      logic [31:0] w;
      w = {DEV_ADDR, 24'($urandom)};
      xfer(w, 4'($urandom), bit'($urandom_range(1)), 0, '0);
    end

    repeat (5) @(negedge clk_25M);
    chk32("total_starts", nstart, exp_starts);
    chk32("total_stops", nstop, exp_starts - 1);
    chk32("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
